acc_sequencer: RTL

Control sequencer for the column accumulator bank behind the systolic array. It accepts one accumulation job per command: a number of output tiles, a beat count per tile and a base output-buffer address. For each tile it clears the accumulators, gates accumulation over the valid array beats, waits out the adder drain latency, and issues one store into the output buffer. It sits between the top-level command path and the accumulator, driving the accumulator's reset, store and buffer-address inputs.

---
 rtl/acc_sequencer_if.sv | 52 +++++
 rtl/acc_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/acc_sequencer_if.sv
// Command, array-beat and accumulator-control bundle for acc_sequencer.
// ACC_SEQ_ABORT_EN adds the abort input.
interface acc_sequencer_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_num_tiles;
  logic [CNT_W-1:0]  cmd_tile_len;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic              array_valid;
  logic              buf_full;
  logic              acc_reset;
  logic              acc_enable;
  logic              store_output;
  logic [ADDR_W-1:0] op_buffer_address;
  logic              busy;
  logic              done;

`ifdef ACC_SEQ_ABORT_EN
  logic              abort;

  modport master (
    output cmd_valid, cmd_num_tiles, cmd_tile_len, cmd_base_addr,
    output array_valid, buf_full, abort,
    input  cmd_ready, acc_reset, acc_enable, store_output,
    input  op_buffer_address, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_num_tiles, cmd_tile_len, cmd_base_addr,
    input  array_valid, buf_full, abort,
    output cmd_ready, acc_reset, acc_enable, store_output,
    output op_buffer_address, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_num_tiles, cmd_tile_len, cmd_base_addr,
    output array_valid, buf_full,
    input  cmd_ready, acc_reset, acc_enable, store_output,
    input  op_buffer_address, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_num_tiles, cmd_tile_len, cmd_base_addr,
    input  array_valid, buf_full,
    output cmd_ready, acc_reset, acc_enable, store_output,
    output op_buffer_address, busy, done
  );
`endif
endinterface

// File: rtl/acc_sequencer.sv
// Per-tile clear/accumulate/drain/store sequencer for the column accumulator bank.
// Optional feature: define ACC_SEQ_ABORT_EN to enable the abort input.
module acc_sequencer #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  acc_sequencer_if.slave bus
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  num_tiles;
  logic [CNT_W-1:0]  tile_len;
  logic [CNT_W-1:0]  tile_cnt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] op_addr;
  logic              abort_pulse;
  logic              abort_now;
  logic              drain_last;
  logic              last_beat;
  logic              last_tile;
  logic              store_fire;

`ifdef ACC_SEQ_ABORT_EN
  assign abort_now = bus.abort && (state != S_IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign drain_last = (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));
  assign last_beat  = bus.array_valid && (beat_cnt == tile_len - CNT_W'(1));
  assign last_tile  = (tile_cnt == num_tiles - CNT_W'(1));
  assign store_fire = (state == S_STORE) && !bus.buf_full && !abort_now;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort overrides every non-idle transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.cmd_valid)
                 state_nxt = (bus.cmd_num_tiles == CNT_W'(0)) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nxt = (tile_len == CNT_W'(0)) ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (last_beat) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last) state_nxt = S_STORE;
      S_STORE: if (!bus.buf_full) state_nxt = last_tile ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_IDLE;
  end

  // Output decode from registered state and counters
  always_comb begin
    bus.cmd_ready         = 1'b0;
    bus.busy              = 1'b1;
    bus.done              = 1'b0;
    bus.acc_reset         = abort_pulse;
    bus.acc_enable        = 1'b0;
    bus.store_output      = store_fire;
    bus.op_buffer_address = op_addr;
    case (state)
      S_IDLE:  begin bus.cmd_ready = 1'b1; bus.busy = 1'b0; end
      S_CLEAR: bus.acc_reset  = 1'b1;
      S_ACCUM: bus.acc_enable = bus.array_valid;
      S_DONE:  bus.done       = 1'b1;
      default: ;
    endcase
  end

  // Job fields, counters and store address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_tiles   <= '0;
      tile_len    <= '0;
      tile_cnt    <= '0;
      beat_cnt    <= '0;
      drain_cnt   <= '0;
      cur_addr    <= '0;
      op_addr     <= '0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= abort_now;
      case (state)
        S_IDLE: if (bus.cmd_valid) begin
          num_tiles <= bus.cmd_num_tiles;
          tile_len  <= bus.cmd_tile_len;
          cur_addr  <= bus.cmd_base_addr;
          tile_cnt  <= '0;
        end
        S_CLEAR: begin
          beat_cnt  <= '0;
          drain_cnt <= '0;
        end
        S_ACCUM: if (bus.array_valid) beat_cnt <= beat_cnt + CNT_W'(1);
        S_DRAIN: begin
          if (drain_last) op_addr   <= cur_addr;
          else            drain_cnt <= drain_cnt + DRN_W'(1);
        end
        S_STORE: if (store_fire) begin
          cur_addr <= cur_addr + ADDR_W'(1);
          tile_cnt <= tile_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
